// File: rtl/ras_stack_sync.sv
// Return-address stack for the frontend branch predictor.
// Registered shift-stack: entry 0 is the top, reads come straight from state,
// and updates land on the next rising edge. The entry count masks stale data,
// so a flush only has to clear the count and the event flags.
module ras_stack_sync #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic [VLEN-1:0]            data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [VLEN-1:0] stack_q [DEPTH];
    logic [VLEN-1:0] stack_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    // Next-state decode: flush beats push/pop; flags default low so they pulse.
    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    // Shift down; when full the oldest entry falls off the bottom.
                    for (int i = DEPTH - 1; i >= 1; i--) begin
                        stack_d[i] = stack_q[i-1];
                    end
                    stack_d[0] = data_i;
                    if (count_q < DepthC) begin
                        count_d = count_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (count_q != '0) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            stack_d[i] = stack_q[i+1];
                        end
                        stack_d[DEPTH-1] = '0;
                        count_d          = count_q - CW'(1);
                    end else begin
                        udf_d = 1'b1;
                    end
                end
                2'b11: begin
                    // Return then call: replace the top in place.
                    stack_d[0] = data_i;
                    if (count_q == '0) begin
                        count_d = CW'(1);
                        udf_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            stack_q <= stack_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs come directly from state; data is masked when empty.
    always_comb begin
        valid_o     = (count_q != '0);
        data_o      = valid_o ? stack_q[0] : '0;
        count_o     = count_q;
        overflow_o  = ovf_q;
        underflow_o = udf_q;
    end

endmodule

// File: tb/tb_ras_stack_sync.sv
module tb_ras_stack_sync;

    logic        clk;
    logic        rst, flush, push, pop;
    logic [31:0] din;

    logic [31:0] d_o;
    logic        v_o, ovf_o, udf_o;
    logic [1:0]  c_o;

    logic [31:0] d1_o;
    logic        v1_o, ovf1_o, udf1_o;
    logic [0:0]  c1_o;

    int checks = 0;
    int errors = 0;

    ras_stack_sync #(.DEPTH(2), .VLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(din), .data_o(d_o), .valid_o(v_o), .count_o(c_o),
        .overflow_o(ovf_o), .underflow_o(udf_o)
    );

    ras_stack_sync #(.DEPTH(1), .VLEN(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(din), .data_o(d1_o), .valid_o(v1_o), .count_o(c1_o),
        .overflow_o(ovf1_o), .underflow_o(udf1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, flush, push, pop;
        logic [31:0] data;
        logic [31:0] e_data;
        logic        e_valid;
        logic [1:0]  e_count;
        logic        e_ovf, e_udf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        valid;
        logic [1:0]  count;
        logic        ovf, udf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string n, logic r, logic f, logic pu, logic po,
                                logic [31:0] d, logic [31:0] ed, logic ev,
                                logic [1:0] ec, logic eo, logic eu);
        vec_t v;
        v.name = n; v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.data = d;
        v.e_data = ed; v.e_valid = ev; v.e_count = ec; v.e_ovf = eo; v.e_udf = eu;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic pu, logic po, logic [31:0] d);
        @(negedge clk);
        rst = r; flush = f; push = pu; pop = po; din = d;
    endtask

    task automatic compare_top(exp_t e);
        chk({e.name, ".data"},  d_o,          e.data);
        chk({e.name, ".valid"}, 32'(v_o),     32'(e.valid));
        chk({e.name, ".count"}, 32'(c_o),     32'(e.count));
        chk({e.name, ".ovf"},   32'(ovf_o),   32'(e.ovf));
        chk({e.name, ".udf"},   32'(udf_o),   32'(e.udf));
    endtask

    task automatic chk1(string n, logic [31:0] ed, logic ev, logic ec, logic eo, logic eu);
        chk({n, ".data"},  d1_o,        ed);
        chk({n, ".valid"}, 32'(v1_o),   32'(ev));
        chk({n, ".count"}, 32'(c1_o),   32'(ec));
        chk({n, ".ovf"},   32'(ovf1_o), 32'(eo));
        chk({n, ".udf"},   32'(udf1_o), 32'(eu));
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

        //            name        rst f pu po data          e_data        v cnt o u
        vecs.push_back(mk("rst",      1,0,0,0, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t2.push1", 0,0,1,0, 32'h8000_0100,32'h8000_0100,1,1,0,0));
        vecs.push_back(mk("t2.push2", 0,0,1,0, 32'h8000_0200,32'h8000_0200,1,2,0,0));
        vecs.push_back(mk("t2.pop1",  0,0,0,1, 32'h0,        32'h8000_0100,1,1,0,0));
        vecs.push_back(mk("t2.pop2",  0,0,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t3.pushA", 0,0,1,0, 32'h100,      32'h100,      1,1,0,0));
        vecs.push_back(mk("t3.pushB", 0,0,1,0, 32'h200,      32'h200,      1,2,0,0));
        vecs.push_back(mk("t3.pushC", 0,0,1,0, 32'h300,      32'h300,      1,2,1,0));
        vecs.push_back(mk("t3.idle",  0,0,0,0, 32'h0,        32'h300,      1,2,0,0));
        vecs.push_back(mk("t3.pop1",  0,0,0,1, 32'h0,        32'h200,      1,1,0,0));
        vecs.push_back(mk("t3.pop2",  0,0,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t4.popE",  0,0,0,1, 32'h0,        32'h0,        0,0,0,1));
        vecs.push_back(mk("t4.idle",  0,0,0,0, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t4.pp",    0,0,1,1, 32'h444,      32'h444,      1,1,0,1));
        vecs.push_back(mk("t4.idle2", 0,0,0,0, 32'h0,        32'h444,      1,1,0,0));
        vecs.push_back(mk("t4.pop",   0,0,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t5.push1", 0,0,1,0, 32'h10,       32'h10,       1,1,0,0));
        vecs.push_back(mk("t5.push2", 0,0,1,0, 32'h20,       32'h20,       1,2,0,0));
        vecs.push_back(mk("t5.pp",    0,0,1,1, 32'h30,       32'h30,       1,2,0,0));
        vecs.push_back(mk("t5.pop1",  0,0,0,1, 32'h0,        32'h10,       1,1,0,0));
        vecs.push_back(mk("t5.pop2",  0,0,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t6.push1", 0,0,1,0, 32'h1,        32'h1,        1,1,0,0));
        vecs.push_back(mk("t6.push2", 0,0,1,0, 32'h2,        32'h2,        1,2,0,0));
        vecs.push_back(mk("t6.push3", 0,0,1,0, 32'h3,        32'h3,        1,2,1,0));
        vecs.push_back(mk("t6.flush", 0,1,1,0, 32'h4,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t6.push5", 0,0,1,0, 32'h5,        32'h5,        1,1,0,0));
        vecs.push_back(mk("t6.pop",   0,0,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t6.flpop", 0,1,0,1, 32'h0,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t6.push6", 0,0,1,0, 32'h6,        32'h6,        1,1,0,0));
        vecs.push_back(mk("t6.push7", 0,0,1,0, 32'h7,        32'h7,        1,2,0,0));
        vecs.push_back(mk("t6.rst",   1,0,1,0, 32'h8,        32'h0,        0,0,0,0));
        vecs.push_back(mk("t6.popE",  0,0,0,1, 32'h0,        32'h0,        0,0,0,1));

        // Reset, then 10 idle cycles with everything held at zero.
        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 32'h0);
            e.name = $sformatf("t1.idle%0d", i);
            e.data = '0; e.valid = 0; e.count = 0; e.ovf = 0; e.udf = 0;
            sb.push_back(e);
            @(posedge clk); #1;
            compare_top(sb.pop_front());
        end

        // Table-driven vectors through the scoreboard.
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].flush, vecs[k].push, vecs[k].pop, vecs[k].data);
            e.name = vecs[k].name; e.data = vecs[k].e_data; e.valid = vecs[k].e_valid;
            e.count = vecs[k].e_count; e.ovf = vecs[k].e_ovf; e.udf = vecs[k].e_udf;
            sb.push_back(e);
            @(posedge clk); #1;
            compare_top(sb.pop_front());
        end
        chk("sb.empty", 32'(sb.size()), 32'd0);

        // Single-entry stack: push, overflowing push, pop, underflow.
        drive(1, 0, 0, 0, 32'h0); @(posedge clk); #1; chk1("d1.rst",   32'h0,   0, 0, 0, 0);
        drive(0, 0, 1, 0, 32'hA1); @(posedge clk); #1; chk1("d1.push", 32'hA1,  1, 1, 0, 0);
        drive(0, 0, 1, 0, 32'hB2); @(posedge clk); #1; chk1("d1.ovf",  32'hB2,  1, 1, 1, 0);
        drive(0, 0, 1, 1, 32'hC3); @(posedge clk); #1; chk1("d1.pp",   32'hC3,  1, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h0);  @(posedge clk); #1; chk1("d1.pop",  32'h0,   0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0);  @(posedge clk); #1; chk1("d1.udf",  32'h0,   0, 0, 0, 1);
        drive(0, 0, 0, 0, 32'h0);  @(posedge clk); #1; chk1("d1.idle", 32'h0,   0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
